// File: rtl/lsu_pkg.sv
// Shared funct3 codes and FSM state type for the load/store unit.
package lsu_pkg;

    localparam int unsigned F3_BITS = 3;

    localparam logic [F3_BITS-1:0] F3_B  = 3'd0;
    localparam logic [F3_BITS-1:0] F3_H  = 3'd1;
    localparam logic [F3_BITS-1:0] F3_W  = 3'd2;
    localparam logic [F3_BITS-1:0] F3_BU = 3'd4;
    localparam logic [F3_BITS-1:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        LOAD,
        READ,
        WRITE,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling: merges sub-word store data into an old word and
// selects/extends the addressed lane of a loaded word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Store merge: replace only the addressed byte or half lane.
    always_comb begin
        merged = old_word;
        case (funct3)
            F3_B:    merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H:    merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    // Load lane select followed by sign or zero extension.
    always_comb begin
        load_byte = rdata[{byte_off, 3'b000} +: 8];
        load_half = rdata[{byte_off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
            F3_BU:   load_data = {24'h000000, load_byte};
            F3_H:    load_data = {{16{load_half[15]}}, load_half};
            F3_HU:   load_data = {16'h0000, load_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and a word-addressed RAM.
// Sub-word stores use read-modify-write; bad accesses never reach the RAM.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data
);

    lsu_state_t  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        req_err_c;
    logic [31:0] merged_c;
    logic [31:0] load_ext_c;

    // Request legality: range, funct3 validity and natural alignment.
    always_comb begin
        req_err_c = 1'b0;
        if (req_addr[31:ADDR_W+2] != '0) begin
            req_err_c = 1'b1;
        end
        if (req_write) begin
            if (req_funct3 > F3_W) begin
                req_err_c = 1'b1;
            end
        end else if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) begin
            req_err_c = 1'b1;
        end
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) begin
            req_err_c = 1'b1;
        end
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00) begin
            req_err_c = 1'b1;
        end
    end

    lsu_align u_align (
        .funct3    (f3_q),
        .byte_off  (off_q),
        .old_word  (ram_read_data),
        .wdata     (wdata_q),
        .rdata     (ram_read_data),
        .merged    (merged_c),
        .load_data (load_ext_c)
    );

    // Write enable is gated by reset so a reset edge never commits a write.
    assign MemWrite = write_q & ~RST;

    // Control FSM with registered RAM-side and response-side outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            f3_q           <= 3'd0;
            off_q          <= 2'd0;
            wdata_q        <= 32'h0;
            write_q        <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_error     <= 1'b0;
            ram_address    <= '0;
            ram_write_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        if (req_err_c) begin
                            state <= ERR;
                        end else if (!req_write) begin
                            state       <= LOAD;
                            ram_address <= req_addr[ADDR_W+1:2];
                        end else if (req_funct3 == F3_W) begin
                            state          <= WRITE;
                            write_q        <= 1'b1;
                            ram_address    <= req_addr[ADDR_W+1:2];
                            ram_write_data <= req_wdata;
                        end else begin
                            state       <= READ;
                            ram_address <= req_addr[ADDR_W+1:2];
                        end
                    end
                end
                ERR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b1;
                end
                LOAD: begin
                    state       <= RESP;
                    resp_valid  <= 1'b1;
                    resp_rdata  <= load_ext_c;
                    ram_address <= '0;
                end
                READ: begin
                    state          <= WRITE;
                    write_q        <= 1'b1;
                    ram_write_data <= merged_c;
                end
                WRITE: begin
                    state          <= RESP;
                    write_q        <= 1'b0;
                    resp_valid     <= 1'b1;
                    ram_address    <= '0;
                    ram_write_data <= 32'h0;
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                    resp_error <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: RAM model, byte-addressed reference memory and
// a per-cycle comparator against expected transaction behaviour.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        MemWrite;
    logic [9:0]  ram_address;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] model_mem [0:1023];

    // expectation for the single outstanding transaction
    bit          pending = 0;
    bit          check_en = 0;
    int          cyc = 0;
    int          exp_lat = 0;
    bit          exp_err = 0;
    bit          exp_wr = 0;
    logic [9:0]  exp_word = '0;
    logic [31:0] exp_wword = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_error = 1'b0;
    int          last_lat = 0;
    int          mw_count = 0;
    bit          exp_mw, exp_rv;

    load_store_unit #(.ADDR_W(10), .DATA_W(32)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .MemWrite       (MemWrite),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    always #5 CLK = ~CLK;

    // RAM: combinational read, write on rising edge
    assign ram_read_data = mem[ram_address];
    always @(posedge CLK) begin
        if (MemWrite) begin
            mem[ram_address] <= ram_write_data;
            mw_count <= mw_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        if (a >= 32'h1000) return 1;
        if (wr && f3 > 3'd2) return 1;
        if (!wr && (f3 == 3'd3 || f3 >= 3'd6)) return 1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1;
        if (f3 == 3'd2 && (a % 4 != 0)) return 1;
        return 0;
    endfunction

    // Per-cycle comparison of every output against the pending expectation
    always @(negedge CLK) begin
        if (check_en && !RST) begin
            if (pending) cyc++;
            exp_mw = pending && exp_wr && (cyc == exp_lat - 1);
            exp_rv = pending && (cyc == exp_lat);
            chk("req_ready", 32'(req_ready), 32'(!pending));
            chk("MemWrite", 32'(MemWrite), 32'(exp_mw));
            if (exp_mw) chk("ram_write_data", ram_write_data, exp_wword);
            else        chk("ram_write_data idle", ram_write_data, 32'h0);
            if (pending && !exp_err && cyc < exp_lat)
                chk("ram_address", 32'(ram_address), 32'(exp_word));
            else
                chk("ram_address idle", 32'(ram_address), 32'h0);
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_error", 32'(resp_error), 32'(exp_err));
                last_rdata = resp_rdata;
                last_error = resp_error;
                last_lat   = cyc;
                pending    = 0;
            end else begin
                chk("resp_rdata idle", resp_rdata, 32'h0);
                chk("resp_error idle", 32'(resp_error), 32'h0);
            end
            if (pending && cyc > exp_lat) begin
                tests++;
                fails++;
                $display("FAIL resp_timeout: no resp_valid after %0d cycles, required %0d", cyc, exp_lat);
                pending = 0;
            end
        end
    end

    task automatic drive_accept(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, output bit ok);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready=%0b, required 1", req_ready);
            return;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        @(posedge CLK);
        #1;
        req_valid  = 1'b0;
        req_wdata  = $urandom;
        req_addr   = $urandom;
    endtask

    // Issue one request, predicting its outcome from the reference memory
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w, v, mask, nw;
        int sh;
        bit ok;
        exp_err   = model_err(wr, f3, a);
        exp_wr    = 0;
        exp_rdata = 32'h0;
        exp_wword = 32'h0;
        exp_word  = a[11:2];
        exp_lat   = 2;
        nw        = 32'h0;
        if (!exp_err) begin
            w  = model_mem[a[11:2]];
            sh = int'(a % 4) * 8;
            if (!wr) begin
                case (f3)
                    3'd0: begin v = (w >> sh) & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
                    3'd4: v = (w >> sh) & 32'hFF;
                    3'd1: begin v = (w >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
                    3'd5: v = (w >> sh) & 32'hFFFF;
                    default: v = w;
                endcase
                exp_rdata = v;
            end else begin
                exp_wr = 1;
                case (f3)
                    3'd0: begin mask = 32'hFF << sh;   nw = (w & ~mask) | ((d & 32'hFF) << sh);   exp_lat = 3; end
                    3'd1: begin mask = 32'hFFFF << sh; nw = (w & ~mask) | ((d & 32'hFFFF) << sh); exp_lat = 3; end
                    default: nw = d;
                endcase
                exp_wword = nw;
            end
        end
        drive_accept(wr, f3, a, d, ok);
        if (!ok) return;
        cyc     = 0;
        pending = 1;
        if (exp_wr) model_mem[a[11:2]] = nw;
        for (int k = 0; k < 10 && pending; k++) @(negedge CLK);
    endtask

    initial begin
        int mw0;
        bit ok;
        for (int i = 0; i < 1024; i++) begin
            mem[i]       = 32'h0;
            model_mem[i] = 32'h0;
        end

        // reset for two cycles
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset resp_valid", 32'(resp_valid), 32'h0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_error", 32'(resp_error), 32'h0);
        chk("reset MemWrite", 32'(MemWrite), 32'h0);
        chk("reset ram_address", 32'(ram_address), 32'h0);
        chk("reset ram_write_data", ram_write_data, 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'h1);
        RST = 1'b0;
        check_en = 1;

        do_req(1, 3'd2, 32'h10, 32'hDEADBEEF);
        chk("SW latency", 32'(last_lat), 32'd2);
        chk("SW ram word 4", mem[4], 32'hDEADBEEF);
        do_req(0, 3'd2, 32'h10, 32'h0);
        chk("LW 0x10", last_rdata, 32'hDEADBEEF);
        chk("LW 0x10 error", 32'(last_error), 32'h0);
        chk("LW latency", 32'(last_lat), 32'd2);

        do_req(1, 3'd0, 32'h11, 32'h000000A5);
        chk("SB latency", 32'(last_lat), 32'd3);
        chk("SB ram word 4", mem[4], 32'hDEADA5EF);
        do_req(0, 3'd0, 32'h11, 32'h0);
        chk("LB 0x11", last_rdata, 32'hFFFFFFA5);
        do_req(0, 3'd4, 32'h11, 32'h0);
        chk("LBU 0x11", last_rdata, 32'h000000A5);

        do_req(1, 3'd1, 32'h12, 32'h00001234);
        chk("SH ram word 4", mem[4], 32'h1234A5EF);
        do_req(0, 3'd1, 32'h12, 32'h0);
        chk("LH 0x12", last_rdata, 32'h00001234);
        do_req(0, 3'd5, 32'h10, 32'h0);
        chk("LHU 0x10", last_rdata, 32'h0000A5EF);

        // error cases must not pulse MemWrite
        mw0 = mw_count;
        do_req(0, 3'd2, 32'h13, 32'h0);
        chk("LW 0x13 error", 32'(last_error), 32'h1);
        chk("LW 0x13 rdata", last_rdata, 32'h0);
        do_req(1, 3'd1, 32'h11, 32'hFFFF);
        chk("SH 0x11 error", 32'(last_error), 32'h1);
        do_req(1, 3'd2, 32'h1000, 32'h55);
        chk("SW 0x1000 error", 32'(last_error), 32'h1);
        do_req(0, 3'd3, 32'h0, 32'h0);
        chk("load f3=3 error", 32'(last_error), 32'h1);
        chk("error MemWrite pulses", 32'(mw_count - mw0), 32'h0);
        chk("word 4 after errors", mem[4], 32'h1234A5EF);

        // reset during the WRITE cycle of an SB
        do_req(1, 3'd2, 32'h20, 32'h11223344);
        check_en = 0;
        drive_accept(1, 3'd0, 32'h20, 32'h000000EE, ok);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("MemWrite under reset", 32'(MemWrite), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        chk("reset-abort resp_valid", 32'(resp_valid), 32'h0);
        chk("reset-abort req_ready", 32'(req_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("reset-abort no resp", 32'(resp_valid), 32'h0);
        end
        chk("reset-abort ram word 8", mem[8], 32'h11223344);
        check_en = 1;
        do_req(0, 3'd2, 32'h20, 32'h0);
        chk("LW 0x20 after abort", last_rdata, 32'h11223344);

        // random aligned store/load pairs
        for (int i = 0; i < 20; i++) begin
            logic [2:0]  sf, lf;
            logic [31:0] word, sa, la;
            int pick;
            sf   = 3'($urandom_range(0, 2));
            word = 32'($urandom_range(0, 1023));
            case (sf)
                3'd0:    sa = word * 4 + 32'($urandom_range(0, 3));
                3'd1:    sa = word * 4 + 32'($urandom_range(0, 1)) * 2;
                default: sa = word * 4;
            endcase
            do_req(1, sf, sa, $urandom);
            pick = $urandom_range(0, 4);
            case (pick)
                0:       begin lf = 3'd0; la = word * 4 + 32'($urandom_range(0, 3)); end
                1:       begin lf = 3'd4; la = word * 4 + 32'($urandom_range(0, 3)); end
                2:       begin lf = 3'd1; la = word * 4 + 32'($urandom_range(0, 1)) * 2; end
                3:       begin lf = 3'd5; la = word * 4 + 32'($urandom_range(0, 1)) * 2; end
                default: begin lf = 3'd2; la = word * 4; end
            endcase
            do_req(0, lf, la, 32'h0);
        end

        repeat (2) @(negedge CLK);
        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
